// File: rtl/jtframe_sdram_pkg.sv
// Shared types and helpers for the jtframe_sdram_resp SDRAM responder.
// State encoding, word-width constants and saturating counters.
package jtframe_sdram_pkg;

   typedef enum logic [1:0] {StIdle, StBusy, StRefresh} state_e;

   localparam int unsigned WORD_W = 16;

   function automatic int unsigned words(input int unsigned dw);
      return dw / WORD_W;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/jtframe_sdram_stats.sv
// Idle/cycle statistics for the SDRAM responder: per-line idle count
// (line ends on hs falling edge), total idle cycles and total cycles.
module jtframe_sdram_stats
   import jtframe_sdram_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        idle,
   input  logic        hs,
   output logic [15:0] idle_line,
   output logic [31:0] idle_total,
   output logic [31:0] cyc_total
);

   logic        hs_q;
   logic [15:0] line_q;
   logic [15:0] line_inc;

   // The edge cycle itself still belongs to the line that is closing.
   assign line_inc = idle ? sat_inc16(line_q) : line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q       <= 1'b0;
         line_q     <= '0;
         idle_line  <= '0;
         idle_total <= '0;
         cyc_total  <= '0;
      end else begin
         hs_q      <= hs;
         cyc_total <= sat_inc32(cyc_total);
         if (idle) idle_total <= sat_inc32(idle_total);
         if (hs_q && !hs) begin
            idle_line <= line_inc;
            line_q    <= '0;
         end else begin
            line_q    <= line_inc;
         end
      end
   end

endmodule

// File: rtl/jtframe_sdram_resp.sv
// Cycle-accurate SDRAM responder backed by a 16-bit word array.
// Refresh stalls are modelled only when JTFRAME_SDRAM_REFRESH_EN is defined.
module jtframe_sdram_resp
   import jtframe_sdram_pkg::*;
#(
   parameter int unsigned AW         = 22,
   parameter int unsigned DW         = 32,
   parameter int unsigned WRW        = 16,
   parameter int unsigned LATENCY    = 6,
   parameter int unsigned REF_PERIOD = 384,
   parameter int unsigned REF_CYCLES = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          sdram_req,
   input  logic [AW-1:0] sdram_addr,
   input  logic          sdram_rnw,
   input  logic [DW-1:0] data_write,
   input  logic          refresh_en,
   input  logic          hs,
   output logic          sdram_ack,
   output logic          data_rdy,
   output logic [DW-1:0] data_read,
   output logic [15:0]   idle_line,
   output logic [31:0]   idle_total,
   output logic [31:0]   cyc_total
);

   localparam int unsigned WORDS = words(DW);

   logic [WORD_W-1:0] mem [0:(2**AW)-1];

   state_e        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [AW-1:0] addr_q;
   logic          rnw_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rd_data;
   logic          accept, done, ref_go, idle;

`ifdef JTFRAME_SDRAM_REFRESH_EN
   logic [31:0] ref_q;

   assign ref_go = (ref_q == '0) && refresh_en;

   always_ff @(posedge clk) begin
      if (rst)                                ref_q <= 32'(REF_PERIOD - 1);
      else if (state_q == StIdle && ref_go)   ref_q <= 32'(REF_PERIOD - 1);
      else if (ref_q != '0)                   ref_q <= ref_q - 32'd1;
   end
`else
   logic unused_ref;
   assign unused_ref = refresh_en ^ (REF_PERIOD == 0);
   assign ref_go     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ref_go) begin
               state_d = StRefresh;
               cnt_d   = 16'(REF_CYCLES - 1);
            end else if (sdram_req) begin
               accept  = 1'b1;
               state_d = StBusy;
               cnt_d   = 16'(LATENCY - 1);
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 16'd1;
            // Completion lands on the edge that brings the counter to 0.
            if (cnt_q == 16'd1) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         StRefresh: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < WORDS; i++) begin
         rd_data[i*WORD_W +: WORD_W] = mem[addr_q + AW'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         addr_q    <= '0;
         rnw_q     <= 1'b1;
         wdata_q   <= '0;
         sdram_ack <= 1'b0;
         data_rdy  <= 1'b0;
         data_read <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sdram_ack <= accept;
         data_rdy  <= done;
         if (accept) begin
            addr_q  <= sdram_addr;
            rnw_q   <= sdram_rnw;
            wdata_q <= data_write;
         end
         if (done && rnw_q) data_read <= rd_data;
      end
   end

   // Array is never reset so contents survive a mid-operation reset.
   always_ff @(posedge clk) begin
      if (!rst && done && !rnw_q) begin
         if (WRW == DW) begin
            for (int i = 0; i < WORDS; i++) begin
               mem[addr_q + AW'(i)] <= wdata_q[i*WORD_W +: WORD_W];
            end
         end else begin
            mem[addr_q] <= wdata_q[WORD_W-1:0];
         end
      end
   end

   assign idle = (state_q == StIdle) && !sdram_req;

   jtframe_sdram_stats u_stats (
      .clk        (clk),
      .rst        (rst),
      .idle       (idle),
      .hs         (hs),
      .idle_line  (idle_line),
      .idle_total (idle_total),
      .cyc_total  (cyc_total)
   );

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Self-checking bench for jtframe_sdram_resp: table of transactions with a
// read-data scoreboard, plus back-to-back, reset, stats and refresh sequences.
module tb_jtframe_sdram_resp;

   localparam int LAT0 = 6;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hs  = 1'b0;

   logic        req0 = 1'b0, rnw0 = 1'b1, ref_en0 = 1'b0;
   logic [9:0]  addr0 = '0;
   logic [31:0] wd0 = '0;
   logic        ack0, rdy0;
   logic [31:0] rd0;
   logic [15:0] il0;
   logic [31:0] it0, ct0;

   logic        req1 = 1'b0, rnw1 = 1'b1;
   logic [3:0]  addr1 = '0;
   logic [63:0] wd1 = '0;
   logic        ack1, rdy1;
   logic [63:0] rd1;
   logic [15:0] il1;
   logic [31:0] it1, ct1;

   always #5 clk = ~clk;

   jtframe_sdram_resp #(
      .AW(10), .DW(32), .WRW(16), .LATENCY(LAT0), .REF_PERIOD(8), .REF_CYCLES(4)
   ) u0 (
      .clk(clk), .rst(rst), .sdram_req(req0), .sdram_addr(addr0), .sdram_rnw(rnw0),
      .data_write(wd0), .refresh_en(ref_en0), .hs(hs), .sdram_ack(ack0), .data_rdy(rdy0),
      .data_read(rd0), .idle_line(il0), .idle_total(it0), .cyc_total(ct0)
   );

   jtframe_sdram_resp #(
      .AW(4), .DW(64), .WRW(64), .LATENCY(LAT1), .REF_PERIOD(384), .REF_CYCLES(4)
   ) u1 (
      .clk(clk), .rst(rst), .sdram_req(req1), .sdram_addr(addr1), .sdram_rnw(rnw1),
      .data_write(wd1), .refresh_en(1'b0), .hs(hs), .sdram_ack(ack1), .data_rdy(rdy1),
      .data_read(rd1), .idle_line(il1), .idle_total(it1), .cyc_total(ct1)
   );

   typedef struct {
      bit          inst;
      bit          rnw;
      logic [9:0]  addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   vec_t        tbl [13];
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];
   logic [63:0] last0 = '0, last1 = '0;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected data_read after each data_rdy; writes must leave the last read value.
   task automatic push(input bit inst, input bit rnw, input logic [63:0] exp);
      if (inst) begin
         if (rnw) last1 = exp;
         q1.push_back(last1);
      end else begin
         if (rnw) last0 = exp;
         q0.push_back(last0);
      end
   endtask

   always @(negedge clk) begin
      if (rdy0) begin
         if (q0.size() == 0) check("u0_unexpected_rdy", 64'd1, 64'd0);
         else check("u0_data", {32'h0, rd0}, q0.pop_front());
      end
      if (rdy1) begin
         if (q1.size() == 0) check("u1_unexpected_rdy", 64'd1, 64'd0);
         else check("u1_data", rd1, q1.pop_front());
      end
   end

   task automatic do_txn(input vec_t v);
      int ack_at, rdy_at, lat;
      lat    = v.inst ? LAT1 : LAT0;
      ack_at = -1;
      rdy_at = -1;
      push(v.inst, v.rnw, v.exp);
      if (v.inst) begin
         req1 = 1'b1; rnw1 = v.rnw; addr1 = v.addr[3:0]; wd1 = v.wdata;
      end else begin
         req0 = 1'b1; rnw0 = v.rnw; addr0 = v.addr; wd0 = v.wdata[31:0];
      end
      for (int c = 1; c <= 40 && rdy_at < 0; c++) begin
         @(negedge clk);
         if ((v.inst ? ack1 : ack0) && ack_at < 0) begin
            ack_at = c;
            req0   = 1'b0;
            req1   = 1'b0;
         end
         if (v.inst ? rdy1 : rdy0) rdy_at = c;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("ack_cycle", 64'(ack_at), 64'(1));
      check("rdy_cycle", 64'(rdy_at), 64'(lat));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      last0 = '0;
      last1 = '0;
   endtask

   initial begin
      logic [31:0] ack_m, rdy_m;
      int          n_ack, n_rdy;

      tbl[0]  = '{1'b0, 1'b0, 10'h100, 64'h0000_1234, 64'h0};
      tbl[1]  = '{1'b0, 1'b0, 10'h101, 64'hFFFF_ABCD, 64'h0};
      tbl[2]  = '{1'b0, 1'b1, 10'h100, 64'h0, 64'hABCD_1234};
      tbl[3]  = '{1'b0, 1'b0, 10'h021, 64'h0000_7777, 64'h0};
      tbl[4]  = '{1'b0, 1'b0, 10'h020, 64'hFFFF_5A5A, 64'h0};
      tbl[5]  = '{1'b0, 1'b1, 10'h020, 64'h0, 64'h7777_5A5A};
      tbl[6]  = '{1'b0, 1'b0, 10'h3FF, 64'h0000_BEEF, 64'h0};
      tbl[7]  = '{1'b0, 1'b0, 10'h000, 64'h0000_C0DE, 64'h0};
      tbl[8]  = '{1'b0, 1'b1, 10'h3FF, 64'h0, 64'hC0DE_BEEF};
      tbl[9]  = '{1'b1, 1'b0, 10'h00E, 64'h1111_0000_FFFF_EEEE, 64'h0};
      tbl[10] = '{1'b1, 1'b0, 10'h002, 64'h5555_4444_3333_2222, 64'h0};
      tbl[11] = '{1'b1, 1'b1, 10'h00E, 64'h0, 64'h1111_0000_FFFF_EEEE};
      tbl[12] = '{1'b1, 1'b1, 10'h000, 64'h0, 64'h3333_2222_1111_0000};

`ifndef JTFRAME_SDRAM_REFRESH_EN
      ref_en0 = 1'b1;
`endif

      repeat (2) @(negedge clk);
      check("rst_ack",  {63'h0, ack0}, 64'h0);
      check("rst_rdy",  {63'h0, rdy0}, 64'h0);
      check("rst_data", {32'h0, rd0},  64'h0);
      check("rst_line", {48'h0, il0},  64'h0);
      check("rst_idle", {32'h0, it0},  64'h0);
      check("rst_cyc",  {32'h0, ct0},  64'h0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) do_txn(tbl[i]);

      // Back-to-back reads with sdram_req held: accept every LAT0 cycles.
      ack_m = '0; rdy_m = '0; n_ack = 0; n_rdy = 0;
      for (int k = 0; k < 3; k++) push(1'b0, 1'b1, 64'hABCD_1234);
      req0 = 1'b1; rnw0 = 1'b1; addr0 = 10'h100;
      for (int c = 1; c < 30; c++) begin
         @(negedge clk);
         if (ack0) begin ack_m[c] = 1'b1; n_ack++; end
         if (rdy0) begin rdy_m[c] = 1'b1; n_rdy++; end
         if (n_ack == 3) req0 = 1'b0;
      end
      check("b2b_ack_mask", {32'h0, ack_m}, 64'h0000_2082);
      check("b2b_rdy_mask", {32'h0, rdy_m}, 64'h0004_1040);

      // Reset during a BUSY read: access is dropped, memory retained.
      req0 = 1'b1; rnw0 = 1'b1; addr0 = 10'h101;
      @(negedge clk);
      check("mid_ack", {63'h0, ack0}, 64'h1);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();
      check("mid_rst_data", {32'h0, rd0}, 64'h0);
      check("mid_rst_cyc",  {32'h0, ct0}, 64'h0);
      check("mid_rst_idle", {32'h0, it0}, 64'h0);
      check("mid_rst_line", {48'h0, il0}, 64'h0);
      n_rdy = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rdy0) n_rdy++;
      end
      check("mid_no_rdy", 64'(n_rdy), 64'h0);
      do_txn('{1'b0, 1'b1, 10'h100, 64'h0, 64'hABCD_1234});

      // Idle statistics over two hs lines of 100 cycles.
      do_reset();
      hs = 1'b1;
      repeat (50) @(negedge clk);
      hs = 1'b0;
      repeat (50) @(negedge clk);
      check("line_first", {48'h0, il0}, 64'd51);
      hs = 1'b1;
      repeat (50) @(negedge clk);
      hs = 1'b0;
      @(negedge clk);
      check("line_second", {48'h0, il0}, 64'd100);
      check("cyc_total",   {32'h0, ct0}, 64'd151);
      check("idle_total",  {32'h0, it0}, 64'd151);

`ifdef JTFRAME_SDRAM_REFRESH_EN
      // Refresh becomes pending together with a new request and wins.
      do_reset();
      ref_en0 = 1'b1;
      repeat (7) @(negedge clk);
      push(1'b0, 1'b1, 64'hABCD_1234);
      req0 = 1'b1; rnw0 = 1'b1; addr0 = 10'h100;
      n_ack = -1; n_rdy = -1;
      for (int c = 1; c <= 20 && n_rdy < 0; c++) begin
         @(negedge clk);
         if (ack0 && n_ack < 0) begin n_ack = c; req0 = 1'b0; end
         if (rdy0) n_rdy = c;
      end
      req0    = 1'b0;
      ref_en0 = 1'b0;
      check("ref_ack_cycle", 64'(n_ack), 64'd6);
      check("ref_rdy_cycle", 64'(n_rdy), 64'd11);
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(q0.size() + q1.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
